// File: rtl/dram_sched.sv
// FSB-to-DRAM strobe sequencer: row/column access with CAS-before-RAS refresh
// arbitration and a saturating refresh-pending counter. Outputs are state decodes.
module dram_sched #(
  parameter int TCAS = 2,
  parameter int TRP  = 2,
  parameter int TRAS = 3
) (
  input  logic CLK,
  input  logic RES,
  input  logic BACT,
  input  logic RAMCS,
  input  logic nWE,
  input  logic RefReq,
  input  logic RefUrg,
  output logic nRAS,
  output logic nCAS,
  output logic RowSel,
  output logic nOE,
  output logic RAMReady,
  output logic RefAck
);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, DONE, PRE, REFC, REFR
  } state_t;

  state_t     state, nextState;
  logic [2:0] cnt, cntNext;
  logic [1:0] pending, pendInc, pendNext;
  logic       nWEq;
  logic       doneFirst;
  logic       cntLast;

  assign cntLast = (cnt == 3'd1);

  // Arbitration sees this cycle's RefReq so a pulse in IDLE is served at once.
  always_comb begin
    pendInc = pending;
    if (RefReq && pending != 2'd3) pendInc = pending + 2'd1;
  end

  always_comb begin
    pendNext = pendInc;
    if (RefAck) begin
      if (RefReq)              pendNext = pending;
      else if (pending != '0)  pendNext = pending - 2'd1;
      else                     pendNext = pending;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if ((RefUrg || pendInc >= 2'd2) && pendInc != '0) nextState = REFC;
        else if (BACT && RAMCS)                            nextState = ROW;
        else if (pendInc != '0 && !BACT)                   nextState = REFC;
      end
      ROW:  nextState = BACT ? COL : PRE;
      COL: begin
        if (!BACT)        nextState = PRE;
        else if (cntLast) nextState = DONE;
      end
      DONE: if (!BACT)    nextState = PRE;
      PRE:  if (cntLast)  nextState = IDLE;
      REFC: nextState = REFR;
      REFR: if (cntLast)  nextState = PRE;
      default: nextState = IDLE;
    endcase
  end

  // Timers load on state entry and count down; a state exits when it reads 1.
  always_comb begin
    cntNext = cnt;
    if (nextState != state) begin
      unique case (nextState)
        COL:     cntNext = 3'(TCAS);
        PRE:     cntNext = 3'(TRP);
        REFR:    cntNext = 3'(TRAS);
        default: cntNext = '0;
      endcase
    end else if (cnt > 3'd1) begin
      cntNext = cnt - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= '0;
      nWEq      <= 1'b1;
      doneFirst <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= cntNext;
      pending   <= pendNext;
      doneFirst <= (state != DONE) && (nextState == DONE);
      if (state == IDLE && nextState == ROW) nWEq <= nWE;
    end
  end

  always_comb begin
    nRAS     = 1'b1;
    nCAS     = 1'b1;
    RowSel   = 1'b1;
    nOE      = 1'b1;
    RAMReady = 1'b0;
    RefAck   = 1'b0;
    unique case (state)
      ROW:  nRAS = 1'b0;
      COL: begin
        nRAS   = 1'b0;
        nCAS   = 1'b0;
        RowSel = 1'b0;
        nOE    = ~nWEq;
      end
      DONE: begin
        nRAS     = 1'b0;
        nCAS     = 1'b0;
        RowSel   = 1'b0;
        nOE      = ~nWEq;
        RAMReady = doneFirst;
      end
      REFC: begin
        nCAS   = 1'b0;
        RefAck = 1'b1;
      end
      REFR: begin
        nCAS = 1'b0;
        nRAS = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_sched.sv
// Directed bench for dram_sched with default timing (TCAS=2, TRP=2, TRAS=3).
// Output word checked each cycle: {nRAS, nCAS, RowSel, nOE, RAMReady, RefAck}.
module tb_dram_sched;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  logic BACT = 1'b0, RAMCS = 1'b0, nWE = 1'b1, RefReq = 1'b0, RefUrg = 1'b0;
  logic nRAS, nCAS, RowSel, nOE, RAMReady, RefAck;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] O_IDLE = 6'b111100;
  localparam logic [5:0] O_PRE  = 6'b111100;
  localparam logic [5:0] O_ROW  = 6'b011100;
  localparam logic [5:0] O_COLR = 6'b000000;
  localparam logic [5:0] O_COLW = 6'b000100;
  localparam logic [5:0] O_RDYR = 6'b000010;
  localparam logic [5:0] O_RDYW = 6'b000110;
  localparam logic [5:0] O_REFC = 6'b101101;
  localparam logic [5:0] O_REFR = 6'b001100;

  dram_sched dut (
    .CLK(CLK), .RES(RES), .BACT(BACT), .RAMCS(RAMCS), .nWE(nWE),
    .RefReq(RefReq), .RefUrg(RefUrg),
    .nRAS(nRAS), .nCAS(nCAS), .RowSel(RowSel), .nOE(nOE),
    .RAMReady(RAMReady), .RefAck(RefAck)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       bact, ramcs, nwe, refReq, refUrg, res;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic b, r, w, q, u, s, input logic [5:0] e, input string n);
    vec_t v;
    v.bact = b; v.ramcs = r; v.nwe = w; v.refReq = q; v.refUrg = u; v.res = s;
    v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic b, r, w, q, u, s);
    BACT = b; RAMCS = r; nWE = w; RefReq = q; RefUrg = u; RES = s;
  endtask

  // Inputs set here are sampled at the next rising edge; outputs checked 1ns after it.
  task automatic tick(input string name, input logic [5:0] exp);
    logic [5:0] act;
    @(posedge CLK);
    #1;
    act = {nRAS, nCAS, RowSel, nOE, RAMReady, RefAck};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic run(input string name, input logic [5:0] exp, input int n);
    for (int i = 0; i < n; i++) tick(name, exp);
  endtask

  initial begin
    // reset, read access with late BACT drop, PRE length, ROW abort, write, COL abort
    addVec(0,0,1,0,0,1, O_IDLE, "reset0");
    addVec(0,0,1,0,0,1, O_IDLE, "reset1");
    addVec(1,0,1,0,0,0, O_IDLE, "nonram_idle");
    addVec(0,0,1,0,1,0, O_IDLE, "urg_no_pending");
    addVec(1,1,1,0,0,0, O_ROW,  "rd_row");
    addVec(1,1,1,0,0,0, O_COLR, "rd_col1");
    addVec(1,1,1,0,0,0, O_COLR, "rd_col2");
    addVec(1,1,1,0,0,0, O_RDYR, "rd_ready");
    addVec(1,1,1,0,0,0, O_COLR, "rd_hold5");
    addVec(1,1,1,0,0,0, O_COLR, "rd_hold6");
    addVec(0,0,1,0,0,0, O_PRE,  "rd_pre1");
    addVec(1,1,1,0,0,0, O_PRE,  "rd_pre2");
    addVec(1,1,1,0,0,0, O_IDLE, "rd_idle");
    addVec(1,1,1,0,0,0, O_ROW,  "row_again");
    addVec(0,0,1,0,0,0, O_PRE,  "row_abort_pre1");
    addVec(0,0,1,0,0,0, O_PRE,  "row_abort_pre2");
    addVec(0,0,1,0,0,0, O_IDLE, "row_abort_idle");
    addVec(1,1,0,0,0,0, O_ROW,  "wr_row");
    addVec(1,1,1,0,0,0, O_COLW, "wr_col1");
    addVec(1,1,1,0,0,0, O_COLW, "wr_col2");
    addVec(1,1,1,0,0,0, O_RDYW, "wr_ready");
    addVec(1,1,1,0,0,0, O_COLW, "wr_hold");
    addVec(0,0,1,0,0,0, O_PRE,  "wr_pre1");
    addVec(0,0,1,0,0,0, O_PRE,  "wr_pre2");
    addVec(0,0,1,0,0,0, O_IDLE, "wr_idle");
    addVec(1,1,1,0,0,0, O_ROW,  "ab_row");
    addVec(1,1,1,0,0,0, O_COLR, "ab_col");
    addVec(0,0,1,0,0,0, O_PRE,  "ab_pre1");
    addVec(0,0,1,0,0,0, O_PRE,  "ab_pre2");
    addVec(0,0,1,0,0,0, O_IDLE, "ab_idle1");
    addVec(0,0,1,0,0,0, O_IDLE, "ab_idle2");

    foreach (vecs[i]) begin
      drive(vecs[i].bact, vecs[i].ramcs, vecs[i].nwe, vecs[i].refReq, vecs[i].refUrg, vecs[i].res);
      tick(vecs[i].name, vecs[i].exp);
    end

    // refresh from idle
    drive(0,0,1,1,0,0); tick("ref_ack", O_REFC);
    drive(0,0,1,0,0,0); run("ref_ras", O_REFR, 3);
    run("ref_pre", O_PRE, 2);
    run("ref_done_idle", O_IDLE, 3);

    // pending refresh waits while a non-DRAM bus cycle is active
    drive(1,0,1,1,0,0); tick("nonram_pend_idle1", O_IDLE);
    drive(1,0,1,0,0,0); tick("nonram_pend_idle2", O_IDLE);
    drive(0,0,1,0,0,0); tick("nonram_ref", O_REFC);
    run("nonram_refr", O_REFR, 3);
    run("nonram_pre", O_PRE, 2);
    tick("nonram_idle", O_IDLE);

    // contention, not urgent: access first, refresh after PRE
    drive(1,1,1,1,0,0); tick("c0_row", O_ROW);
    drive(1,1,1,0,0,0); run("c0_col", O_COLR, 2);
    tick("c0_ready", O_RDYR);
    drive(0,0,1,0,0,0); run("c0_pre", O_PRE, 2);
    tick("c0_idle", O_IDLE);
    tick("c0_refc", O_REFC);
    run("c0_refr", O_REFR, 3);
    run("c0_pre2", O_PRE, 2);
    tick("c0_idle2", O_IDLE);

    // contention, urgent: refresh first, held access starts from IDLE after PRE
    drive(1,1,1,1,1,0); tick("c1_refc", O_REFC);
    drive(1,1,1,0,0,0); run("c1_refr", O_REFR, 3);
    run("c1_pre", O_PRE, 2);
    tick("c1_idle", O_IDLE);
    tick("c1_row", O_ROW);
    run("c1_col", O_COLR, 2);
    tick("c1_ready", O_RDYR);
    drive(0,0,1,0,0,0); run("c1_pre2", O_PRE, 2);
    tick("c1_idle2", O_IDLE);

    // four refresh pulses during a held access saturate pending at 3
    drive(1,1,1,0,0,0); tick("sat_row", O_ROW);
    drive(1,1,1,1,0,0); tick("sat_col1", O_COLR);
    drive(1,1,1,0,0,0); tick("sat_col2", O_COLR);
    drive(1,1,1,1,0,0); tick("sat_ready", O_RDYR);
    drive(1,1,1,0,0,0); tick("sat_hold1", O_COLR);
    drive(1,1,1,1,0,0); tick("sat_hold2", O_COLR);
    drive(1,1,1,0,0,0); tick("sat_hold3", O_COLR);
    drive(1,1,1,1,0,0); tick("sat_hold4", O_COLR);
    drive(0,0,1,0,0,0); run("sat_pre", O_PRE, 2);
    tick("sat_idle", O_IDLE);
    for (int k = 0; k < 3; k++) begin
      tick($sformatf("sat_refc%0d", k), O_REFC);
      run($sformatf("sat_refr%0d", k), O_REFR, 3);
      run($sformatf("sat_pre%0d", k), O_PRE, 2);
      tick($sformatf("sat_idle%0d", k), O_IDLE);
    end
    run("sat_drained", O_IDLE, 2);

    // reset in second REFR cycle clears pending and returns straight to IDLE
    drive(0,0,1,1,0,0); tick("rr_refc", O_REFC);
    drive(0,0,1,1,0,0); tick("rr_refr1", O_REFR);
    drive(0,0,1,0,0,0); tick("rr_refr2", O_REFR);
    drive(0,0,1,0,0,1); tick("rr_reset", O_IDLE);
    drive(0,0,1,0,0,0); run("rr_pend_clear", O_IDLE, 3);

    // reset mid-COL: next access starts immediately, no PRE inserted
    drive(1,1,1,0,0,0); tick("rc_row", O_ROW);
    tick("rc_col", O_COLR);
    drive(1,1,1,0,0,1); tick("rc_reset", O_IDLE);
    drive(1,1,1,0,0,0); tick("rc_row_again", O_ROW);
    drive(0,0,1,0,0,0); run("rc_pre", O_PRE, 2);
    tick("rc_idle", O_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
